gshare_bht: RTL and testbench
=============================

GSHARE_BHT -- requirements
Module: gshare_bht

Interface
REQ-001 SHALL have parameter VLEN, default 39, virtual address width.
REQ-002 SHALL have parameter NR_ENTRIES, default 1024, total predictor entries (power of two).
REQ-003 SHALL have parameter INSTR_PER_FETCH, default 2, entries per row (power of two).
REQ-004 SHALL have parameter CTR_BITS, default 2, saturating counter width (>=2).
REQ-005 SHALL have parameter HIST_BITS, default 8, global history width (>=2).
REQ-006 SHALL have parameter RVC, default 1, compressed-instruction support; OFFSET=1 if RVC else 2.
REQ-007 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-008 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-009 SHALL have port flush_bp_i  in  1  start table invalidation sweep.
REQ-010 SHALL have port debug_mode_i  in  1  suppress counter training.
REQ-011 SHALL have port vpc_i  in  VLEN  fetch PC to predict.
REQ-012 SHALL have ports spec_valid_i and spec_taken_i, both in, 1 bit; a branch is predicted and its speculative direction.
REQ-013 SHALL have ports update_valid_i, update_taken_i and update_mispredict_i, all in, 1 bit; a resolved branch, its outcome, and whether it mispredicted.
REQ-014 SHALL have port update_pc_i  in  VLEN  resolved branch PC.
REQ-015 SHALL have port update_hist_i  in  HIST_BITS  history snapshot taken at prediction.
REQ-016 SHALL have port pred_valid_o  out  INSTR_PER_FETCH  per-slot entry valid.
REQ-017 SHALL have port pred_taken_o  out  INSTR_PER_FETCH  per-slot taken prediction.
REQ-018 SHALL have port hist_o  out  HIST_BITS  current speculative global history.
REQ-019 SHALL have port ready_o  out  1  table usable (no sweep in progress).

Function
REQ-020 SHALL hold NR_ROWS=NR_ENTRIES/INSTR_PER_FETCH rows; each entry is a valid bit plus a CTR_BITS counter.
REQ-021 SHALL form the row index as PC[IB+RA+OFFSET-1:RA+OFFSET] XOR the history, where IB=log2(NR_ROWS) and RA=log2(INSTR_PER_FETCH); history is zero-extended or truncated to IB bits.
REQ-022 SHALL select the update column from update_pc_i[RA+OFFSET-1:OFFSET] when RVC=1, and use column 0 when RVC=0.
REQ-023 SHALL drive predictions combinationally from the row at index(vpc_i, hist_o): valid = entry valid; taken = counter MSB; both are 0 while ready_o=0.
REQ-024 SHALL, on update_valid_i with ready_o=1 and debug_mode_i=0, set the entry valid and step the counter +1 if taken, -1 if not; the counter saturates at 2^CTR_BITS-1 and at 0. The entry is indexed with update_hist_i.
REQ-025 SHALL make writes visible from the next cycle; a same-cycle read returns the old value.
REQ-026 SHALL shift history on spec_valid_i: hist <= {hist[HIST_BITS-2:0], spec_taken_i}.
REQ-027 SHALL restore history on update_valid_i with update_mispredict_i: hist <= {update_hist_i[HIST_BITS-2:0], update_taken_i}. This takes priority over a same-cycle spec_valid_i and applies regardless of debug_mode_i.
REQ-028 SHALL implement an FSM with states IDLE and SWEEP plus a row counter.
- SWEEP: each cycle writes one row (all slots valid=0, counter=2^(CTR_BITS-1)), increments the row counter, and moves to IDLE after row NR_ROWS-1.
- ready_o = (state==IDLE).
REQ-029 SHALL, on flush_bp_i in any state, enter SWEEP with row counter 0 and clear history to 0; flush during SWEEP restarts the sweep.
REQ-030 SHALL ignore updates and spec_valid_i while in SWEEP; flush_bp_i takes priority over all same-cycle events.

Reset
REQ-031 SHALL, on rst_i, set state=SWEEP, row counter=0 and hist=0; ready_o=0, pred_valid_o=0, pred_taken_o=0, hist_o=0 until the sweep completes.
REQ-032 SHALL leave table contents undefined until the first sweep completes, and SHALL restart the sweep if rst_i asserts mid-operation.

Verification (NR_ENTRIES=16, INSTR_PER_FETCH=2, CTR_BITS=2, HIST_BITS=4, RVC=1)
REQ-033 SHALL cover: rst_i for 1 cycle -> ready_o=0 for exactly 8 cycles then 1; pred_valid_o=0, hist_o=0.
REQ-034 SHALL cover: after the sweep, update pc=0x4, hist=0, not taken -> next cycle, vpc_i=0x4 with hist_o=0 gives pred_valid_o[0]=1, pred_taken_o[0]=0 (counter 2->1).
REQ-035 SHALL cover: three taken updates to a fresh entry -> counter 3 and saturated; one not-taken update -> counter 2, taken still 1.
REQ-036 SHALL cover: spec taken 1,1,0 -> hist_o=4'b0110; then mispredict with update_hist_i=4'b0011, taken=0, plus same-cycle spec_valid_i -> hist_o=4'b0110; also vpc_i=0x4 with hist_o=4'b0010 reads row 3.
REQ-037 SHALL cover: flush_bp_i at sweep row 5 -> sweep restarts and ready_o stays 0 for 8 more cycles; an update during the sweep or with debug_mode_i=1 leaves its counter unchanged.

Source files
------------

// File: rtl/gshare_bht.sv
// Gshare branch history table: PC xor global history selects a row of
// per-slot valid bits and saturating counters; a sweep FSM invalidates the table.
module gshare_bht #(
    parameter int unsigned VLEN            = 39,
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned CTR_BITS        = 2,
    parameter int unsigned HIST_BITS       = 8,
    parameter int unsigned RVC             = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_bp_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       spec_valid_i,
    input  logic                       spec_taken_i,
    input  logic                       update_valid_i,
    input  logic                       update_taken_i,
    input  logic                       update_mispredict_i,
    input  logic [VLEN-1:0]            update_pc_i,
    input  logic [HIST_BITS-1:0]       update_hist_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
    output logic [HIST_BITS-1:0]       hist_o,
    output logic                       ready_o
);

    localparam int unsigned NR_ROWS = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned IB      = (NR_ROWS > 1) ? $clog2(NR_ROWS) : 1;
    localparam int unsigned RA      = $clog2(INSTR_PER_FETCH);
    localparam int unsigned CW      = (RA > 0) ? RA : 1;
    localparam int unsigned OFFSET  = (RVC != 0) ? 1 : 2;

    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [IB-1:0]       ROW_LAST = IB'(NR_ROWS - 1);

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e                state_q, state_d;
    logic [IB-1:0]         row_q, row_d;
    logic [HIST_BITS-1:0]  hist_q, hist_d;

    logic                  valid_q [NR_ROWS][INSTR_PER_FETCH];
    logic [CTR_BITS-1:0]   ctr_q   [NR_ROWS][INSTR_PER_FETCH];

    logic [IB-1:0]         rd_row, upd_row;
    logic [CW-1:0]         upd_col;
    logic [VLEN-1:0]       upd_pc_sh;
    logic [CTR_BITS-1:0]   upd_ctr, upd_ctr_d;
    logic                  sweep_we, upd_we;

    // History is zero-extended (or truncated) to IB bits before the xor.
    function automatic logic [IB-1:0] row_index(input logic [VLEN-1:0] pc,
                                                input logic [HIST_BITS-1:0] hist);
        logic [VLEN-1:0]         pc_sh;
        logic [IB+HIST_BITS-1:0] hist_ext;
        pc_sh    = pc >> (RA + OFFSET);
        hist_ext = {{IB{1'b0}}, hist};
        return pc_sh[IB-1:0] ^ hist_ext[IB-1:0];
    endfunction

    assign rd_row   = row_index(vpc_i, hist_q);
    assign upd_row  = row_index(update_pc_i, update_hist_i);
    assign ready_o  = (state_q == IDLE);
    assign hist_o   = hist_q;
    assign sweep_we = (state_q == SWEEP) && !rst_i && !flush_bp_i;
    assign upd_we   = (state_q == IDLE) && !rst_i && !flush_bp_i
                      && update_valid_i && !debug_mode_i;

    always_comb begin
        upd_pc_sh = update_pc_i >> OFFSET;
        upd_col   = '0;
        if (RVC != 0 && RA > 0) begin
            upd_col = upd_pc_sh[CW-1:0];
        end
    end

    always_comb begin
        upd_ctr   = ctr_q[upd_row][upd_col];
        upd_ctr_d = upd_ctr;
        if (update_taken_i && upd_ctr != CTR_MAX) begin
            upd_ctr_d = upd_ctr + CTR_ONE;
        end else if (!update_taken_i && upd_ctr != '0) begin
            upd_ctr_d = upd_ctr - CTR_ONE;
        end
    end

    always_comb begin
        pred_valid_o = '0;
        pred_taken_o = '0;
        if (ready_o) begin
            for (int unsigned s = 0; s < INSTR_PER_FETCH; s++) begin
                pred_valid_o[s] = valid_q[rd_row][s];
                pred_taken_o[s] = ctr_q[rd_row][s][CTR_BITS-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        hist_d  = hist_q;
        if (flush_bp_i) begin
            state_d = SWEEP;
            row_d   = '0;
            hist_d  = '0;
        end else begin
            case (state_q)
                SWEEP: begin
                    row_d = row_q + IB'(1);
                    if (row_q == ROW_LAST) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    // Mispredict restore wins over a same-cycle speculative shift.
                    if (update_valid_i && update_mispredict_i) begin
                        hist_d = {update_hist_i[HIST_BITS-2:0], update_taken_i};
                    end else if (spec_valid_i) begin
                        hist_d = {hist_q[HIST_BITS-2:0], spec_taken_i};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SWEEP;
            row_q   <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            hist_q  <= hist_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (sweep_we) begin
            for (int unsigned s = 0; s < INSTR_PER_FETCH; s++) begin
                valid_q[row_q][s] <= 1'b0;
                ctr_q[row_q][s]   <= CTR_INIT;
            end
        end else if (upd_we) begin
            valid_q[upd_row][upd_col] <= 1'b1;
            ctr_q[upd_row][upd_col]   <= upd_ctr_d;
        end
    end

endmodule

// File: tb/tb_gshare_bht.sv
// Directed bench for gshare_bht (16 entries, 2 per row, 2-bit counters, 4-bit history)
// with a per-cycle comparison against an abstract table model.
module tb_gshare_bht;

    localparam int VLEN = 39;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            debug = 1'b0;
    logic [VLEN-1:0] vpc = '0;
    logic            spec_valid = 1'b0;
    logic            spec_taken = 1'b0;
    logic            upd_valid = 1'b0;
    logic            upd_taken = 1'b0;
    logic            upd_mis = 1'b0;
    logic [VLEN-1:0] upd_pc = '0;
    logic [3:0]      upd_hist = '0;
    logic [1:0]      pred_valid, pred_taken;
    logic [3:0]      hist_o;
    logic            ready;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    // Abstract model: flat entry arrays, a "sweep in progress" flag and the row being cleared.
    int m_ctr [16];
    bit m_valid [16];
    int m_hist = 0;
    bit m_sweep = 1'b1;
    int m_srow = 0;

    gshare_bht #(
        .VLEN(VLEN), .NR_ENTRIES(16), .INSTR_PER_FETCH(2),
        .CTR_BITS(2), .HIST_BITS(4), .RVC(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_bp_i(flush), .debug_mode_i(debug),
        .vpc_i(vpc), .spec_valid_i(spec_valid), .spec_taken_i(spec_taken),
        .update_valid_i(upd_valid), .update_taken_i(upd_taken),
        .update_mispredict_i(upd_mis), .update_pc_i(upd_pc),
        .update_hist_i(upd_hist), .pred_valid_o(pred_valid),
        .pred_taken_o(pred_taken), .hist_o(hist_o), .ready_o(ready)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic int row_of(input int pc, input int h);
        return ((pc >> 2) & 7) ^ (h & 7);
    endfunction

    always @(posedge clk) begin
        if (rst || flush) begin
            m_sweep = 1'b1;
            m_srow  = 0;
            m_hist  = 0;
        end else if (m_sweep) begin
            for (int s = 0; s < 2; s++) begin
                m_valid[m_srow*2+s] = 1'b0;
                m_ctr[m_srow*2+s]   = 2;
            end
            if (m_srow == 7) m_sweep = 1'b0;
            else m_srow++;
        end else begin
            if (upd_valid && !debug) begin
                int e;
                e = row_of(int'(upd_pc[4:0]), int'(upd_hist)) * 2 + int'(upd_pc[1]);
                m_valid[e] = 1'b1;
                if (upd_taken) m_ctr[e] = (m_ctr[e] == 3) ? 3 : m_ctr[e] + 1;
                else           m_ctr[e] = (m_ctr[e] == 0) ? 0 : m_ctr[e] - 1;
            end
            if (upd_valid && upd_mis)
                m_hist = ((int'(upd_hist) << 1) | int'(upd_taken)) & 15;
            else if (spec_valid)
                m_hist = ((m_hist << 1) | int'(spec_taken)) & 15;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int ev, et, r;
            ev = 0;
            et = 0;
            if (!m_sweep) begin
                r = row_of(int'(vpc[4:0]), m_hist);
                for (int s = 0; s < 2; s++) begin
                    if (m_valid[r*2+s]) ev |= (1 << s);
                    if (m_ctr[r*2+s] >= 2) et |= (1 << s);
                end
            end
            check("cyc_ready", int'(ready), m_sweep ? 0 : 1);
            check("cyc_hist", int'(hist_o), m_hist);
            check("cyc_pred_valid", int'(pred_valid), ev);
            check("cyc_pred_taken", int'(pred_taken), et);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input int pc, input int h, input bit tk, input bit mis);
        logic [31:0] hv;
        hv = h;
        upd_valid = 1'b1;
        upd_pc    = VLEN'(pc);
        upd_hist  = hv[3:0];
        upd_taken = tk;
        upd_mis   = mis;
        step();
        upd_valid = 1'b0;
        upd_mis   = 1'b0;
    endtask

    task automatic look(input int pc);
        vpc = VLEN'(pc);
        #1;
    endtask

    task automatic count_sweep(output int n);
        n = 0;
        while (!ready && n < 20) begin
            step();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int n;
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_ready", int'(ready), 0);
        check("rst_pred_valid", int'(pred_valid), 0);
        check("rst_hist", int'(hist_o), 0);
        count_sweep(n);
        check("rst_sweep_len", n, 8);

        // Row 1 column 0: counter 2 -> 1; column 1 still swept (counter 2).
        upd(4, 0, 1'b0, 1'b0);
        look(4);
        check("first_upd_valid", int'(pred_valid), 2'b01);
        check("first_upd_taken", int'(pred_taken), 2'b10);

        // Row 1 column 1: saturate high, then step down.
        repeat (3) upd(6, 0, 1'b1, 1'b0);
        look(6);
        check("sat_hi_valid", int'(pred_valid), 2'b11);
        check("sat_hi_taken", int'(pred_taken), 2'b10);
        upd(6, 0, 1'b0, 1'b0);
        check("sat_hi_dec1", int'(pred_taken), 2'b10);
        upd(6, 0, 1'b0, 1'b0);
        check("sat_hi_dec2", int'(pred_taken), 2'b00);

        // Row 2 column 0: saturate low.
        repeat (3) upd(8, 0, 1'b0, 1'b0);
        look(8);
        check("sat_lo_taken", int'(pred_taken), 2'b10);

        spec_valid = 1'b1;
        spec_taken = 1'b1; step();
        spec_taken = 1'b1; step();
        spec_taken = 1'b0; step();
        spec_valid = 1'b0;
        check("spec_hist", int'(hist_o), 4'b0110);

        upd_valid = 1'b1; upd_pc = VLEN'(32'h10); upd_hist = 4'b0011;
        upd_taken = 1'b0; upd_mis = 1'b1;
        spec_valid = 1'b1; spec_taken = 1'b1;
        step();
        upd_valid = 1'b0; upd_mis = 1'b0; spec_valid = 1'b0;
        check("mis_restore_hist", int'(hist_o), 4'b0110);

        upd(4, 2, 1'b1, 1'b0);
        upd(32'h1C, 1, 1'b0, 1'b1);
        check("restore_hist2", int'(hist_o), 4'b0010);
        look(4);
        check("row3_valid", int'(pred_valid), 2'b01);
        check("row3_taken", int'(pred_taken), 2'b11);

        flush = 1'b1; step(); flush = 1'b0;
        check("flush_hist", int'(hist_o), 0);
        check("flush_ready", int'(ready), 0);
        repeat (5) step();
        flush = 1'b1; step(); flush = 1'b0;
        n = 0;
        while (!ready && n < 20) begin
            upd_valid  = (n == 3);
            upd_pc     = '0;
            upd_hist   = '0;
            upd_taken  = 1'b0;
            spec_valid = (n == 3);
            spec_taken = 1'b1;
            step();
            n++;
        end
        upd_valid = 1'b0; spec_valid = 1'b0;
        check("restart_sweep_len", n, 8);
        look(0);
        check("sweep_upd_ignored_v", int'(pred_valid), 2'b00);
        check("sweep_upd_ignored_t", int'(pred_taken), 2'b11);
        check("sweep_spec_ignored", int'(hist_o), 0);

        debug = 1'b1;
        upd(0, 0, 1'b0, 1'b0);
        check("debug_upd_v", int'(pred_valid), 2'b00);
        check("debug_upd_t", int'(pred_taken), 2'b11);
        upd(0, 5, 1'b1, 1'b1);
        debug = 1'b0;
        check("debug_restore_hist", int'(hist_o), 4'hB);
        repeat (3) step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
